// File: rtl/tft_timing_gen_if.sv
// Pixel source bus between tft_timing_gen and a char/picture generator.
// The generator answers each request PIX_LAT clocks later on pix_data.
interface tft_timing_gen_if #(
  parameter int DATA_W = 16,
  parameter int XY_W   = 10
);
  logic              pix_req;
  logic [XY_W-1:0]   pix_x;
  logic [XY_W-1:0]   pix_y;
  logic [DATA_W-1:0] pix_data;

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    input  pix_data
  );

  modport slave (
    input  pix_req,
    input  pix_x,
    input  pix_y,
    output pix_data
  );
endinterface

// File: rtl/tft_timing_gen.sv
// Parametrised TFT panel timing: sync/DE, lookahead pixel requests,
// frame-start strobe, run enable and frame-counted backlight soft-start.
module tft_timing_gen #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_VALID  = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_VALID  = 272,
  parameter int V_FRONT  = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_LAT  = 1,
  parameter int DATA_W   = 16,
  parameter int XY_W     = 10,
  parameter int BL_DELAY = 2
) (
  input  logic              tft_clk,
  input  logic              sys_rst,
  input  logic              en,
  tft_timing_gen_if.master  pix,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              tft_de,
  output logic              tft_bl,
  output logic              tft_clk_o,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_ACT0  = H_SYNC + H_BACK;
  localparam int H_ACT1  = H_ACT0 + H_VALID;
  localparam int V_ACT0  = V_SYNC + V_BACK;
  localparam int V_ACT1  = V_ACT0 + V_VALID;
  localparam int HC_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VC_W    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int FC_W    = (BL_DELAY > 0) ? $clog2(BL_DELAY + 1) : 1;
  localparam int LOOK    = PIX_LAT + 1;
  localparam logic S_ON  = SYNC_POL;
  localparam logic S_OFF = !SYNC_POL;

  logic [HC_W-1:0]   cnt_h_q, cnt_h_d;
  logic [VC_W-1:0]   cnt_v_q, cnt_v_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic              req_q, req_d;
  logic [XY_W-1:0]   pix_x_q, pix_x_d;
  logic [XY_W-1:0]   pix_y_q, pix_y_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic              fs_q, fs_d;
  logic              seen_q, seen_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              bl_q, bl_d;

  int h, v, ah, av;
  logic h_wrap, v_wrap;

  function automatic logic in_act(input int hc, input int vc);
    return (hc >= H_ACT0) && (hc < H_ACT1) &&
           (vc >= V_ACT0) && (vc < V_ACT1);
  endfunction

  always_comb begin
    h      = int'(cnt_h_q);
    v      = int'(cnt_v_q);
    h_wrap = (h == H_TOTAL - 1);
    v_wrap = (v == V_TOTAL - 1);

    cnt_h_d = h_wrap ? '0 : cnt_h_q + 1'b1;
    cnt_v_d = cnt_v_q;
    if (h_wrap) cnt_v_d = v_wrap ? '0 : cnt_v_q + 1'b1;

    // Request position runs LOOK clocks ahead; wrapping past the
    // line end moves to the next row (and the next frame).
    ah = h + LOOK;
    av = v;
    if (ah >= H_TOTAL) begin
      ah = ah - H_TOTAL;
      av = v_wrap ? 0 : v + 1;
    end

    hsync_d = (h < H_SYNC) ? S_ON : S_OFF;
    vsync_d = (v < V_SYNC) ? S_ON : S_OFF;
    de_d    = in_act(h, v);
    req_d   = in_act(ah, av);
    pix_x_d = req_d ? XY_W'(ah - H_ACT0) : '1;
    pix_y_d = req_d ? XY_W'(av - V_ACT0) : '1;
    rgb_d   = de_d ? pix.pix_data : '0;
    fs_d    = (h == 0) && (v == 0);

    if (!en) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
      hsync_d = S_OFF;
      vsync_d = S_OFF;
      de_d    = 1'b0;
      req_d   = 1'b0;
      pix_x_d = '1;
      pix_y_d = '1;
      rgb_d   = '0;
      fs_d    = 1'b0;
    end

    // The first frame_start only arms the counter.
    seen_d = seen_q;
    fcnt_d = fcnt_q;
    if (fs_q) begin
      seen_d = 1'b1;
      if (seen_q && (int'(fcnt_q) < BL_DELAY)) fcnt_d = fcnt_q + 1'b1;
    end
    bl_d = bl_q | (fs_q && (fcnt_d == FC_W'(BL_DELAY)));
  end

  always_ff @(posedge tft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      hsync_q <= S_OFF;
      vsync_q <= S_OFF;
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      pix_x_q <= '1;
      pix_y_q <= '1;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      seen_q  <= 1'b0;
      fcnt_q  <= '0;
      bl_q    <= 1'b0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      req_q   <= req_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      seen_q  <= seen_d;
      fcnt_q  <= fcnt_d;
      bl_q    <= bl_d;
    end
  end

  assign pix.pix_req  = req_q;
  assign pix.pix_x    = pix_x_q;
  assign pix.pix_y    = pix_y_q;
  assign rgb          = rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign tft_de       = de_q;
  assign tft_bl       = bl_q;
  assign frame_start  = fs_q;
  assign tft_clk_o    = tft_clk;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen: three small-panel builds (latency 1/0/3)
// checked cycle by cycle against a position model plus an rgb scoreboard.
module tb_tft_timing_gen;

  localparam int HS = 2, HB = 1, HV = 4, HF = 1;
  localparam int VS = 1, VB = 1, VV = 3, VF = 1;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;
  localparam int LAT [3] = '{1, 0, 3};
  localparam bit POL [3] = '{1'b0, 1'b0, 1'b1};
  localparam int BLD [3] = '{2, 0, 0};

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   checks = 0;
  int   failures = 0;
  int   fs_seen = 0;
  logic [15:0] sq0[$];
  logic [15:0] sq1[$];
  logic [15:0] sq2[$];

  always #5 clk = ~clk;

  tft_timing_gen_if #(.DATA_W(16), .XY_W(8)) pif0 ();
  tft_timing_gen_if #(.DATA_W(16), .XY_W(8)) pif1 ();
  tft_timing_gen_if #(.DATA_W(16), .XY_W(8)) pif2 ();

  logic [2:0]       hs, vs, de, bl, co, fs, rq;
  logic [2:0][7:0]  px, py;
  logic [2:0][15:0] rg;

  tft_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .SYNC_POL(1'b0), .PIX_LAT(1), .DATA_W(16), .XY_W(8), .BL_DELAY(2)
  ) dut (
    .tft_clk(clk), .sys_rst(rst), .en(en), .pix(pif0),
    .rgb(rg[0]), .hsync(hs[0]), .vsync(vs[0]), .tft_de(de[0]),
    .tft_bl(bl[0]), .tft_clk_o(co[0]), .frame_start(fs[0])
  );

  tft_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .SYNC_POL(1'b0), .PIX_LAT(0), .DATA_W(16), .XY_W(8), .BL_DELAY(0)
  ) dut_l0 (
    .tft_clk(clk), .sys_rst(rst), .en(en), .pix(pif1),
    .rgb(rg[1]), .hsync(hs[1]), .vsync(vs[1]), .tft_de(de[1]),
    .tft_bl(bl[1]), .tft_clk_o(co[1]), .frame_start(fs[1])
  );

  tft_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
    .SYNC_POL(1'b1), .PIX_LAT(3), .DATA_W(16), .XY_W(8), .BL_DELAY(0)
  ) dut_l3 (
    .tft_clk(clk), .sys_rst(rst), .en(en), .pix(pif2),
    .rgb(rg[2]), .hsync(hs[2]), .vsync(vs[2]), .tft_de(de[2]),
    .tft_bl(bl[2]), .tft_clk_o(co[2]), .frame_start(fs[2])
  );

  // Pixel sources returning {row, column} with the configured latency.
  logic [15:0]      d1;
  logic [2:0][15:0] d3;

  always @(posedge clk) d1 <= {pif0.pix_y, pif0.pix_x};
  always @(posedge clk) begin
    d3[0] <= {pif2.pix_y, pif2.pix_x};
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  assign pif0.pix_data = d1;
  assign pif1.pix_data = {pif1.pix_y, pif1.pix_x};
  assign pif2.pix_data = d3[2];

  assign rq[0] = pif0.pix_req;
  assign rq[1] = pif1.pix_req;
  assign rq[2] = pif2.pix_req;
  assign px[0] = pif0.pix_x;
  assign px[1] = pif1.pix_x;
  assign px[2] = pif2.pix_x;
  assign py[0] = pif0.pix_y;
  assign py[1] = pif1.pix_y;
  assign py[2] = pif2.pix_y;

  function automatic logic m_de(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return (h >= HS + HB) && (h < HS + HB + HV) &&
           (v >= VS + VB) && (v < VS + VB + VV);
  endfunction

  function automatic logic [15:0] m_pix(input int p);
    int x, y;
    x = (p % HT) - (HS + HB);
    y = (p / HT) - (VS + VB);
    return {y[7:0], x[7:0]};
  endfunction

  task automatic clear_sb();
    sq0.delete();
    sq1.delete();
    sq2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks += 7;
      if (hs[d] !== !POL[d]) begin
        failures++;
        $display("FAIL rst_hsync dut%0d got=%b exp=%b", d, hs[d], !POL[d]);
      end
      if (vs[d] !== !POL[d]) begin
        failures++;
        $display("FAIL rst_vsync dut%0d got=%b exp=%b", d, vs[d], !POL[d]);
      end
      if ({de[d], rq[d], fs[d], bl[d]} !== 4'b0000) begin
        failures++;
        $display("FAIL rst_flags dut%0d got=%b exp=0000", d,
                 {de[d], rq[d], fs[d], bl[d]});
      end
      if (px[d] !== 8'hFF) begin
        failures++;
        $display("FAIL rst_pix_x dut%0d got=%h exp=ff", d, px[d]);
      end
      if (py[d] !== 8'hFF) begin
        failures++;
        $display("FAIL rst_pix_y dut%0d got=%h exp=ff", d, py[d]);
      end
      if (rg[d] !== 16'h0) begin
        failures++;
        $display("FAIL rst_rgb dut%0d got=%h exp=0000", d, rg[d]);
      end
      if (co[d] !== clk) begin
        failures++;
        $display("FAIL clk_o dut%0d got=%b exp=%b", d, co[d], clk);
      end
    end
    rst = 1'b0;
    fs_seen = 0;
    clear_sb();
  endtask

  // Cycle n after the origin: sample n shows the decode of position n.
  task automatic test_timing(input int ncyc, input bit on);
    int p, h, v, q;
    logic hs_e, vs_e, de_e, fs_e, rq_e, bl_e, got;
    logic [7:0]  x_e, y_e;
    logic [15:0] pq, rg_e;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      p = n % FT;
      h = p % HT;
      v = p / HT;
      for (int d = 0; d < 3; d++) begin
        q    = (p + LAT[d] + 1) % FT;
        pq   = m_pix(q);
        hs_e = (on && h < HS) ? POL[d] : !POL[d];
        vs_e = (on && v < VS) ? POL[d] : !POL[d];
        de_e = on && m_de(p);
        fs_e = on && (p == 0);
        rq_e = on && m_de(q);
        bl_e = (fs_seen >= BLD[d] + 1);
        x_e  = rq_e ? pq[7:0] : 8'hFF;
        y_e  = rq_e ? pq[15:8] : 8'hFF;
        checks += 8;
        if (hs[d] !== hs_e) begin
          failures++;
          $display("FAIL hsync dut%0d n=%0d got=%b exp=%b", d, n, hs[d], hs_e);
        end
        if (vs[d] !== vs_e) begin
          failures++;
          $display("FAIL vsync dut%0d n=%0d got=%b exp=%b", d, n, vs[d], vs_e);
        end
        if (de[d] !== de_e) begin
          failures++;
          $display("FAIL tft_de dut%0d n=%0d got=%b exp=%b", d, n, de[d], de_e);
        end
        if (fs[d] !== fs_e) begin
          failures++;
          $display("FAIL frame_start dut%0d n=%0d got=%b exp=%b", d, n, fs[d], fs_e);
        end
        if (bl[d] !== bl_e) begin
          failures++;
          $display("FAIL tft_bl dut%0d n=%0d got=%b exp=%b", d, n, bl[d], bl_e);
        end
        if (rq[d] !== rq_e) begin
          failures++;
          $display("FAIL pix_req dut%0d n=%0d got=%b exp=%b", d, n, rq[d], rq_e);
        end
        if ({py[d], px[d]} !== {y_e, x_e}) begin
          failures++;
          $display("FAIL pix_xy dut%0d n=%0d got=%h exp=%h", d, n,
                   {py[d], px[d]}, {y_e, x_e});
        end
        if (rq_e) begin
          case (d)
            0:       sq0.push_back(pq);
            1:       sq1.push_back(pq);
            default: sq2.push_back(pq);
          endcase
        end
        rg_e = 16'h0;
        got  = 1'b1;
        if (de[d] === 1'b1) begin
          got = 1'b0;
          case (d)
            0: if (sq0.size() > 0) begin rg_e = sq0.pop_front(); got = 1'b1; end
            1: if (sq1.size() > 0) begin rg_e = sq1.pop_front(); got = 1'b1; end
            default:
               if (sq2.size() > 0) begin rg_e = sq2.pop_front(); got = 1'b1; end
          endcase
        end
        if (!got) begin
          failures++;
          $display("FAIL rgb_sb dut%0d n=%0d got=%h exp=<none queued>", d, n, rg[d]);
        end else if (rg[d] !== rg_e) begin
          failures++;
          $display("FAIL rgb dut%0d n=%0d got=%h exp=%h", d, n, rg[d], rg_e);
        end
      end
      if (on && p == 0) fs_seen++;
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    clear_sb();
  endtask

  task automatic test_en_restart();
    en = 1'b1;
  endtask

  // Reset lands mid active line; outputs must drop before any edge.
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks += 4;
      if (hs[d] !== !POL[d] || vs[d] !== !POL[d]) begin
        failures++;
        $display("FAIL arst_sync dut%0d got=%b%b exp=%b%b", d, hs[d], vs[d],
                 !POL[d], !POL[d]);
      end
      if ({de[d], rq[d], fs[d]} !== 3'b000) begin
        failures++;
        $display("FAIL arst_flags dut%0d got=%b exp=000", d,
                 {de[d], rq[d], fs[d]});
      end
      if (bl[d] !== 1'b0) begin
        failures++;
        $display("FAIL arst_bl dut%0d got=%b exp=0", d, bl[d]);
      end
      if (rg[d] !== 16'h0) begin
        failures++;
        $display("FAIL arst_rgb dut%0d got=%h exp=0000", d, rg[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    fs_seen = 0;
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_timing(122, 1'b1);
    test_en_drop();
    test_timing(20, 1'b0);
    test_en_restart();
    test_timing(77, 1'b1);
    test_async_reset();
    test_timing(60, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tft_timing_gen.md
Name: tft_timing_gen

Overview:
- Parametrised successor of the team's fixed 480x272 TFT controller.
- Generates hsync/vsync/data-enable timing for any panel resolution, porch set and sync polarity from a single pixel clock.
- Issues pixel requests with a configurable lookahead so registered or ROM-based pixel sources (char/picture generators) can return data in time.
- Adds a frame-start strobe, a run/stop enable and a frame-counted backlight soft-start. It sits between the clk_gen output and the pixel source, driving the panel pins.

Parameters:
H_SYNC, 41, hsync pulse width (clocks)
H_BACK, 2, horizontal back porch
H_VALID, 480, active pixels per line
H_FRONT, 2, horizontal front porch
V_SYNC, 10, vsync pulse width (lines)
V_BACK, 2, vertical back porch
V_VALID, 272, active lines
V_FRONT, 2, vertical front porch
SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high), shared by hsync/vsync
PIX_LAT, 1, pixel source latency in clocks (0..4)
DATA_W, 16, rgb width
XY_W, 10, pix_x/pix_y width
BL_DELAY, 2, complete frames before tft_bl rises (0 = immediately after reset)

Ports:
tft_clk  in  1  pixel clock
sys_rst  in  1  asynchronous active-high reset
en  in  1  run enable; low freezes timing at frame origin
pix_data  in  DATA_W  pixel returned by source
pix_req  out  1  pixel request strobe
pix_x  out  XY_W  requested column, all-ones when pix_req low
pix_y  out  XY_W  requested row, all-ones when pix_req low
rgb  out  DATA_W  panel data, 0 outside active area
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
tft_de  out  1  data enable
tft_bl  out  1  backlight enable
tft_clk_o  out  1  panel clock (= tft_clk)
frame_start  out  1  one-cycle pulse at frame origin

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- cnt_h counts 0..H_TOTAL-1 and wraps.
- cnt_v increments when cnt_h wraps, counts 0..V_TOTAL-1 and wraps.
- Reset:
  - Counters go to 0.
  - Every output is registered and resets inactive: hsync = vsync = ~SYNC_POL, tft_de = 0, pix_req = 0, pix_x = pix_y = all-ones, rgb = 0, tft_bl = 0, frame_start = 0.
- Sync/DE outputs are registered decodes of the counters and lag them by 1 clock:
  - hsync active while cnt_h < H_SYNC.
  - vsync active while cnt_v < V_SYNC.
  - tft_de high while cnt_h is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) and cnt_v is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID).
- Pixel requests:
  - pix_req for pixel (k, r) is high exactly PIX_LAT+1 clocks before the tft_de cycle of that pixel.
  - pix_x = k (0..H_VALID-1) and pix_y = r (0..V_VALID-1) while pix_req is high.
  - Requests stream contiguously: H_VALID cycles per active line.
  - Requests never cross a line boundary incorrectly. Lookahead arithmetic wraps cnt_h modulo H_TOTAL. A request whose lookahead lands in the previous line's front porch takes the correct next row.
- Source contract: pix_data for a request must be valid exactly PIX_LAT clocks after that request. PIX_LAT = 0 means the same cycle, combinationally.
- rgb is registered: rgb <= pix_data when the next tft_de = 1, else 0. Result: rgb is aligned with tft_de.
- frame_start: one-cycle pulse, coincident with the first registered hsync-active cycle of vsync line 0.
- Backlight:
  - A frame counter saturates at BL_DELAY, incrementing on each frame_start after the first.
  - tft_bl goes 1 on the cycle after the count reaches BL_DELAY and stays high until reset.
- en:
  - Sampled every clock. When en = 0, counters load 0 and sync/DE/req/rgb outputs go to their reset values next clock.
  - tft_bl and the frame counter hold their values.
  - On en rising, timing restarts from the origin and frame_start pulses.
- Reset asserted mid-frame: all outputs become inactive immediately (asynchronously). After release, the first frame starts at the origin.
- Widths: counters are sized from H_TOTAL/V_TOTAL. Requirement: H_VALID and V_VALID ≤ 2^XY_W - 1.

Test Plan:
- Small config (H 2/1/4/1, V 1/1/3/1, PIX_LAT=1, SYNC_POL=0), reset release -> H_TOTAL=8, V_TOTAL=6.
  - hsync low for 2 of every 8 clocks.
  - vsync low for the first 8 clocks of every 48.
  - tft_de high 4 clocks on each of 3 lines, 12 per frame.
- Same config, source returns pix_data = {pix_y, pix_x} registered (PIX_LAT=1) -> rgb shows 0x000..0x003, 0x100..0x103, 0x200..0x203 exactly on tft_de cycles, 0 elsewhere.
- PIX_LAT=0 and PIX_LAT=3 -> pix_req leads tft_de by 1 and 4 clocks respectively.
  - First request of each line carries pix_x=0 and the correct pix_y, including when the lookahead wraps into the previous line.
- BL_DELAY=2 -> tft_bl stays 0 through frames 0-1 and rises 1 clock after the third frame_start. BL_DELAY=0 -> tft_bl rises right after the first frame_start.
- Drop en for 20 clocks mid-frame -> outputs inactive within 1 clock, tft_bl stays 1; on re-enable frame_start pulses and a full 48-clock frame follows.
- Assert sys_rst mid-active line -> hsync=vsync=1, tft_de=0, rgb=0, tft_bl=0 immediately, without a clock edge.
  - Next frame_start occurs at the first clock after release.
  - SYNC_POL=1 build: reset level of hsync/vsync is 0.
